inst_rom_arbiter: RTL
=====================

Name: inst_rom_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters: the pipeline fetch stage (IF) and the debug/monitor read port (DBG).
- Fetch has fixed priority. A starvation counter forces a DBG grant after MAX_WAIT consecutive lost cycles.
- Checks alignment and range before the ROM is accessed, and returns registered read data one cycle after each grant.
- Sits between pc_reg/if_id and inst_rom.

Parameters:
ADDR_W, 32, byte-address width of every address port
DATA_W, 64, instruction width (8 bytes per instruction)
MEM_LOG2, 17, log2 of ROM depth in instructions; valid byte addresses are 0 .. 2^(MEM_LOG2+3)-8
MAX_WAIT, 4, consecutive lost DBG arbitration cycles before DBG is forced to win (range 1..15)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high (RstEnable = 1)
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch byte address
if_gnt  out  1  fetch granted this cycle (combinational)
if_rvalid  out  1  fetch response valid (registered)
if_rdata  out  DATA_W  fetch instruction
if_err  out  1  fetch response error (misaligned or out of range)
dbg_req  in  1  debug read request; held until dbg_gnt
dbg_addr  in  ADDR_W  debug byte address
dbg_gnt  out  1  debug granted this cycle (combinational)
dbg_rvalid  out  1  debug response valid (registered)
dbg_rdata  out  DATA_W  debug read data
dbg_err  out  1  debug response error
rom_ce  out  1  ROM chip enable (ChipEnable = 1)
rom_addr  out  ADDR_W  ROM byte address
rom_inst  in  DATA_W  ROM data, combinational from rom_ce/rom_addr

Behaviour:
- Reset (rst=1 at a clock edge) clears the following:
  - if_rvalid, dbg_rvalid, if_err and dbg_err go to 0; if_rdata and dbg_rdata go to 0.
  - wait_cnt goes to 0 and the FSM goes to NORMAL.
- While rst=1, if_gnt=dbg_gnt=0, rom_ce=0 and rom_addr=0.
- A response pending when reset arrives is dropped; no rvalid follows.
- FSM states:
  - NORMAL: IF wins whenever if_req=1. DBG is granted only when if_req=0 and dbg_req=1.
  - FORCE_DBG: DBG wins whenever dbg_req=1. If dbg_req=0, IF may be granted.
- wait_cnt (4-bit):
  - Increments when dbg_req=1 and dbg_gnt=0; saturates at MAX_WAIT.
  - Clears on any dbg_gnt, or when dbg_req=0.
- Transitions:
  - NORMAL -> FORCE_DBG at the edge where wait_cnt becomes MAX_WAIT.
  - FORCE_DBG -> NORMAL at the edge where dbg_gnt=1, or when dbg_req=0.
- Exactly one grant per cycle at most. With no request, no grant, rom_ce=0 and rom_addr=0.
- Grant is combinational in the request cycle; the address is consumed in that cycle.
- Access check on the granted address A:
  - Error if A[2:0]!=0 or A[ADDR_W-1:MEM_LOG2+3]!=0.
  - On error: rom_ce=0, and next cycle rvalid=1, err=1, rdata=0.
  - Otherwise: rom_ce=1, rom_addr=A, and next cycle rvalid=1, err=0, rdata=rom_inst.
- Latency is exactly 1 cycle grant->rvalid. rvalid is a single-cycle pulse per grant and rdata holds its value until the next response. There is no backpressure on responses.
- Back-to-back grants to the same requester give consecutive rvalid pulses, allowing 1 instruction per cycle.
- Simultaneous requests: a same-cycle grant to one requester never corrupts the other requester's pending response. Responses are per-port registers.

Test Plan:
- Reset and idle:
  - Stimulus: rst=1 for 2 cycles with if_req=1, if_addr=0x8.
  - Required: gnt=0, rom_ce=0, rvalid=0. After release, first cycle if_gnt=1, and next cycle if_rvalid=1 with if_rdata=ROM[1].
- IF streaming:
  - Stimulus: if_req=1 with addresses 0x0,0x8,0x10 on successive cycles.
  - Required: if_gnt=1 each cycle, and if_rvalid=1 on 3 consecutive cycles with ROM[0],ROM[1],ROM[2] and err=0.
- Starvation (MAX_WAIT=4):
  - Stimulus: if_req=1 and dbg_req=1 continuously, dbg_addr=0x18.
  - Required: IF granted cycles 0-3, dbg_gnt=1 in cycle 4 with if_gnt=0, dbg_rvalid in cycle 5 with ROM[3], IF regranted in cycle 5, and the pattern repeats every 5 cycles.
- Idle-IF debug:
  - Stimulus: if_req=0, dbg_req=1, dbg_addr=0x30.
  - Required: immediate dbg_gnt, next cycle dbg_rvalid=1 with ROM[6], and wait_cnt stays 0.
- Errors:
  - Stimulus: if_addr=0x4 (misaligned), then dbg_addr=0x0010_0000 (out of range for MEM_LOG2=17).
  - Required: gnt=1, rom_ce=0, next cycle rvalid=1, err=1, rdata=0.
- Reset mid-operation:
  - Stimulus: grant in cycle N with rst=1 at edge N+1.
  - Required: no rvalid at N+1, wait_cnt=0, FSM=NORMAL.

Source files
------------

// File: rtl/inst_rom_arbiter.sv
// inst_rom_arbiter: shares one combinational instruction ROM between the fetch
// stage (IF) and the debug read port (DBG). Fetch has fixed priority, and a
// starvation counter forces a DBG win after MAX_WAIT lost cycles. Each granted
// address is checked for alignment and range. The response is registered per
// port one cycle after the grant.
module inst_rom_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MEM_LOG2 = 17,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  // debug port
  input  logic              dbg_req_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_err_o,
  // ROM side
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned HI_LSB = MEM_LOG2 + 3;
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {
    NORMAL    = 1'b0,
    FORCE_DBG = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;

  logic               if_rvalid_q, if_rvalid_d;
  logic               if_err_q, if_err_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic               dbg_rvalid_q, dbg_rvalid_d;
  logic               dbg_err_q, dbg_err_d;
  logic [DATA_W-1:0]  dbg_rdata_q, dbg_rdata_d;

  logic               if_gnt, dbg_gnt;
  logic [ADDR_W-1:0]  sel_addr;
  logic               addr_err;
  logic [DATA_W-1:0]  rsp_data;

  // Arbitration, address check and ROM drive for the current cycle.
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        NORMAL: begin
          if_gnt  = if_req_i;
          dbg_gnt = dbg_req_i & ~if_req_i;
        end
        FORCE_DBG: begin
          dbg_gnt = dbg_req_i;
          if_gnt  = if_req_i & ~dbg_req_i;
        end
        default: ;
      endcase
    end
    sel_addr   = dbg_gnt ? dbg_addr_i : if_addr_i;
    addr_err   = (|sel_addr[2:0]) | (|sel_addr[ADDR_W-1:HI_LSB]);
    rom_ce_o   = (if_gnt | dbg_gnt) & ~addr_err;
    rom_addr_o = rom_ce_o ? sel_addr : '0;
    rsp_data   = addr_err ? '0 : rom_inst_i;
  end

  // Starvation counter and FSM next state.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    if (dbg_req_i && !dbg_gnt) begin
      wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      NORMAL:    if (wait_cnt_d == WAIT_MAX) state_d = FORCE_DBG;
      FORCE_DBG: if (dbg_gnt || !dbg_req_i)  state_d = NORMAL;
      default:   state_d = NORMAL;
    endcase
  end

  // Per-port response next state; data and error hold between responses.
  always_comb begin
    if_rvalid_d  = if_gnt;
    if_err_d     = if_gnt ? addr_err : if_err_q;
    if_rdata_d   = if_gnt ? rsp_data : if_rdata_q;
    dbg_rvalid_d = dbg_gnt;
    dbg_err_d    = dbg_gnt ? addr_err : dbg_err_q;
    dbg_rdata_d  = dbg_gnt ? rsp_data : dbg_rdata_q;
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= NORMAL;
      wait_cnt_q   <= '0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_err_q    <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_err_q    <= dbg_err_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign if_gnt_o     = if_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign if_rvalid_o  = if_rvalid_q;
  assign if_err_o     = if_err_q;
  assign if_rdata_o   = if_rdata_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign dbg_err_o    = dbg_err_q;
  assign dbg_rdata_o  = dbg_rdata_q;

endmodule
